perspective_project: RTL and testbench

//  Downstream stage of the 3D transform. Consumes one transformed float32 vertex
//  (camera space, already shifted +DIST along z) and performs the perspective

---
 rtl/perspective_project.sv | 194 +++++++++++++++++++
 tb/tb_perspective_project.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/perspective_project.sv
// Perspective divide stage: converts a float32 camera-space vertex to Q16.16,
// divides x and y by z with a shared 40-step restoring divider, and emits pixel coordinates.
module perspective_project #(
  parameter int H_RES = 1280,
  parameter int V_RES = 720,
  parameter int FOCAL = 256,
  parameter int Z_MIN = 65536
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [3:0][31:0] pos_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [10:0]      hcount_out,
  output logic [9:0]       vcount_out,
  output logic             visible_out
);

  typedef enum logic [2:0] {
    StIdle,
    StConvert,
    StDivX,
    StDivY,
    StFinish,
    StOutput
  } state_t;

  localparam logic signed [23:0] HCentre = 24'(H_RES / 2);
  localparam logic signed [23:0] VCentre = 24'(V_RES / 2);
  localparam logic signed [23:0] HRes    = 24'(H_RES);
  localparam logic signed [23:0] VRes    = 24'(V_RES);
  localparam logic signed [31:0] ZMin    = 32'(Z_MIN);

  // Float32 to signed Q16.16, truncating toward zero and saturating out-of-range values.
  function automatic logic [31:0] floatToQ(input logic [31:0] f);
    logic [7:0]  e;
    logic [31:0] mant;
    logic [31:0] mag;
    e    = f[30:23];
    mant = {8'd0, 1'b1, f[22:0]};
    if (e == 8'd0)
      mag = 32'd0;
    else if (e >= 8'd142)
      mag = 32'h7FFF_FFFF;
    else if (e >= 8'd134)
      mag = mant << (e - 8'd134);
    else
      mag = mant >> (8'd134 - e);
    return f[31] ? (32'd0 - mag) : mag;
  endfunction

  function automatic logic [39:0] absFocal(input logic [31:0] q);
    logic [31:0] m;
    m = q[31] ? (32'd0 - q) : q;
    return {8'd0, m} * 40'(FOCAL);
  endfunction

  state_t      r_state;
  logic [31:0] r_xf;
  logic [31:0] r_yf;
  logic [31:0] r_zf;
  logic [31:0] r_yq;
  logic [31:0] r_zq;
  logic        r_xNeg;
  logic        r_yNeg;
  logic        r_clip;
  logic [39:0] r_dvd;
  logic [31:0] r_rem;
  logic [5:0]  r_cnt;
  logic [23:0] r_qx;
  logic [23:0] r_qy;

  logic [31:0] w_xq;
  logic [31:0] w_yq;
  logic [31:0] w_zq;
  logic        w_zClip;
  logic [32:0] w_remShift;
  logic        w_ge;
  logic [32:0] w_remNext;
  logic [39:0] w_qNext;
  logic        w_qNeg;
  logic [23:0] w_qSigned;
  logic signed [23:0] w_sx;
  logic signed [23:0] w_sy;
  logic        w_vis;
  logic        w_unused;

  assign w_xq    = floatToQ(r_xf);
  assign w_yq    = floatToQ(r_yf);
  assign w_zq    = floatToQ(r_zf);
  assign w_zClip = $signed(w_zq) < ZMin;

  // The dividend register doubles as the quotient register: quotient bits shift in at the bottom.
  assign w_remShift = {r_rem, r_dvd[39]};
  assign w_ge       = w_remShift >= {1'b0, r_zq};
  assign w_remNext  = w_ge ? (w_remShift - {1'b0, r_zq}) : w_remShift;
  assign w_qNext    = {r_dvd[38:0], w_ge};
  assign w_qNeg     = (r_state == StDivX) ? r_xNeg : r_yNeg;
  assign w_qSigned  = w_qNeg ? (24'd0 - w_qNext[23:0]) : w_qNext[23:0];

  assign w_sx  = HCentre + $signed(r_qx);
  assign w_sy  = VCentre - $signed(r_qy);
  assign w_vis = !r_clip && !w_sx[23] && (w_sx < HRes) && !w_sy[23] && (w_sy < VRes);

  assign w_unused = ^{pos_in[0], w_remNext[32], w_qNext[39:24]};

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state     <= StIdle;
      ready_out   <= 1'b0;
      valid_out   <= 1'b0;
      hcount_out  <= '0;
      vcount_out  <= '0;
      visible_out <= 1'b0;
      r_xf        <= '0;
      r_yf        <= '0;
      r_zf        <= '0;
      r_yq        <= '0;
      r_zq        <= '0;
      r_xNeg      <= 1'b0;
      r_yNeg      <= 1'b0;
      r_clip      <= 1'b0;
      r_dvd       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_qx        <= '0;
      r_qy        <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (valid_in && ready_out) begin
            r_xf      <= pos_in[3];
            r_yf      <= pos_in[2];
            r_zf      <= pos_in[1];
            ready_out <= 1'b0;
            r_state   <= StConvert;
          end else begin
            ready_out <= 1'b1;
          end
        end
        StConvert: begin
          r_clip  <= w_zClip;
          r_zq    <= w_zq;
          r_yq    <= w_yq;
          r_xNeg  <= w_xq[31];
          r_yNeg  <= w_yq[31];
          r_dvd   <= absFocal(w_xq);
          r_rem   <= '0;
          r_cnt   <= '0;
          r_state <= w_zClip ? StFinish : StDivX;
        end
        StDivX: begin
          r_rem <= w_remNext[31:0];
          r_cnt <= r_cnt + 6'd1;
          r_dvd <= w_qNext;
          if (r_cnt == 6'd39) begin
            r_qx    <= w_qSigned;
            r_dvd   <= absFocal(r_yq);
            r_rem   <= '0;
            r_cnt   <= '0;
            r_state <= StDivY;
          end
        end
        StDivY: begin
          r_rem <= w_remNext[31:0];
          r_cnt <= r_cnt + 6'd1;
          r_dvd <= w_qNext;
          if (r_cnt == 6'd39) begin
            r_qy    <= w_qSigned;
            r_state <= StFinish;
          end
        end
        StFinish: begin
          visible_out <= w_vis;
          hcount_out  <= w_vis ? w_sx[10:0] : 11'd0;
          vcount_out  <= w_vis ? w_sy[9:0] : 10'd0;
          valid_out   <= 1'b1;
          r_state     <= StOutput;
        end
        StOutput: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            ready_out <= 1'b1;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_perspective_project.sv
// Directed bench for perspective_project: vector table plus hand-written
// back-pressure and mid-divide reset sequences.
module tb_perspective_project;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    int          expH;
    int          expV;
    logic        expVis;
    int          expLat;
  } vec_t;

  logic             clk;
  logic             rstIn;
  logic             validIn;
  logic             readyOut;
  logic [3:0][31:0] posIn;
  logic             validOut;
  logic             readyIn;
  logic [10:0]      hcountOut;
  logic [9:0]       vcountOut;
  logic             visibleOut;

  int checkCount;
  int errorCount;
  vec_t vecs[16];

  perspective_project dut (
    .clk_in      (clk),
    .rst_in      (rstIn),
    .valid_in    (validIn),
    .ready_out   (readyOut),
    .pos_in      (posIn),
    .valid_out   (validOut),
    .ready_in    (readyIn),
    .hcount_out  (hcountOut),
    .vcount_out  (vcountOut),
    .visible_out (visibleOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Waits for ready, presents one vertex for a single accept edge, then counts edges to valid_out.
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                               output int lat);
    int guard;
    guard = 0;
    while (readyOut !== 1'b1 && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("readyBeforeAccept", 32'(readyOut), 32'd1);
    @(negedge clk);
    posIn   = {x, y, z, 32'h0};
    validIn = 1'b1;
    @(posedge clk);
    #1;
    validIn = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (validOut !== 1'b1 && lat < 200);
  endtask

  task automatic releaseOutput();
    @(negedge clk);
    readyIn = 1'b1;
    @(posedge clk);
    #1;
    readyIn = 1'b0;
    checkOutput("releaseValid", 32'(validOut), 32'd0);
    checkOutput("releaseReady", 32'(readyOut), 32'd1);
  endtask

  task automatic checkResult(input vec_t v, input int lat);
    checkOutput("latency", 32'(lat), 32'(v.expLat));
    checkOutput("hcount", 32'(hcountOut), 32'(v.expH));
    checkOutput("vcount", 32'(vcountOut), 32'(v.expV));
    checkOutput("visible", 32'(visibleOut), 32'(v.expVis));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    checkCount = 0;
    errorCount = 0;
    vecs[0]  = '{32'h3F800000, 32'h00000000, 32'h40000000,  768, 360, 1'b1, 82};
    vecs[1]  = '{32'hBF800000, 32'h3F800000, 32'h40800000,  576, 296, 1'b1, 82};
    vecs[2]  = '{32'h3F800000, 32'h3F800000, 32'h3F000000,    0,   0, 1'b0,  2};
    vecs[3]  = '{32'h41200000, 32'h00000000, 32'h3F800000,    0,   0, 1'b0, 82};
    vecs[4]  = '{32'h3F000000, 32'hBF000000, 32'h3F800000,  768, 488, 1'b1, 82};
    vecs[5]  = '{32'h40200000, 32'h00000000, 32'h3F800000,    0,   0, 1'b0, 82};
    vecs[6]  = '{32'hC0200000, 32'h00000000, 32'h3F800000,    0, 360, 1'b1, 82};
    vecs[7]  = '{32'h00000000, 32'h3FB40000, 32'h3F800000,  640,   0, 1'b1, 82};
    vecs[8]  = '{32'h00000000, 32'hBFB40000, 32'h3F800000,    0,   0, 1'b0, 82};
    vecs[9]  = '{32'h3F800000, 32'h00000000, 32'h40400000,  725, 360, 1'b1, 82};
    vecs[10] = '{32'hBF800000, 32'h00000000, 32'h40400000,  555, 360, 1'b1, 82};
    vecs[11] = '{32'h3F800000, 32'h00000000, 32'hBF800000,    0,   0, 1'b0,  2};
    vecs[12] = '{32'h3F800000, 32'h00000000, 32'h00000000,    0,   0, 1'b0,  2};
    vecs[13] = '{32'h3F800000, 32'h00000000, 32'h3F7FFFFF,    0,   0, 1'b0,  2};
    vecs[14] = '{32'h49742400, 32'h00000000, 32'h3F800000,    0,   0, 1'b0, 82};
    vecs[15] = '{32'hFF800000, 32'h00000000, 32'h3F800000,    0,   0, 1'b0, 82};

    rstIn   = 1'b0;
    validIn = 1'b0;
    readyIn = 1'b0;
    posIn   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetReady", 32'(readyOut), 32'd0);
    checkOutput("resetValid", 32'(validOut), 32'd0);
    checkOutput("resetHcount", 32'(hcountOut), 32'd0);
    checkOutput("resetVcount", 32'(vcountOut), 32'd0);
    checkOutput("resetVisible", 32'(visibleOut), 32'd0);
    @(negedge clk);
    rstIn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("readyAfterReset", 32'(readyOut), 32'd1);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].z, lat);
      checkResult(vecs[i], lat);
      releaseOutput();
    end

    // Back-pressure: results held for 10 cycles and a stray vertex is dropped.
    applyStimulus(vecs[1].x, vecs[1].y, vecs[1].z, lat);
    checkResult(vecs[1], lat);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        posIn   = {vecs[0].x, vecs[0].y, vecs[0].z, 32'h0};
        validIn = 1'b1;
      end
      if (c == 5) validIn = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("holdValid", 32'(validOut), 32'd1);
      checkOutput("holdReady", 32'(readyOut), 32'd0);
      checkOutput("holdHcount", 32'(hcountOut), 32'd576);
      checkOutput("holdVcount", 32'(vcountOut), 32'd296);
      checkOutput("holdVisible", 32'(visibleOut), 32'd1);
    end
    releaseOutput();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput("droppedReady", 32'(readyOut), 32'd1);
      checkOutput("droppedValid", 32'(validOut), 32'd0);
    end

    // Reset in the middle of the x division, then a clean vertex.
    @(negedge clk);
    posIn   = {vecs[0].x, vecs[0].y, vecs[0].z, 32'h0};
    validIn = 1'b1;
    @(posedge clk);
    #1;
    validIn = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rstIn = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midResetReady", 32'(readyOut), 32'd0);
    checkOutput("midResetValid", 32'(validOut), 32'd0);
    checkOutput("midResetHcount", 32'(hcountOut), 32'd0);
    checkOutput("midResetVcount", 32'(vcountOut), 32'd0);
    checkOutput("midResetVisible", 32'(visibleOut), 32'd0);
    @(negedge clk);
    rstIn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midResetReadyRise", 32'(readyOut), 32'd1);
    applyStimulus(vecs[0].x, vecs[0].y, vecs[0].z, lat);
    checkResult(vecs[0], lat);
    releaseOutput();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
